// File: rtl/stl_tl_responder_if.sv
// rtl/stl_tl_responder_if.sv - SerialTL decoded request/response frame bundle for stl_tl_responder.
interface stl_tl_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_chanId;
    logic [2:0]  req_opcode;
    logic [2:0]  req_param;
    logic [7:0]  req_size;
    logic [7:0]  req_source;
    logic [63:0] req_address;
    logic [63:0] req_data;
    logic        req_corrupt;
    logic [8:0]  req_union;

    logic        resp_valid;
    logic        resp_ready;
    logic [2:0]  resp_chanId;
    logic [2:0]  resp_opcode;
    logic [2:0]  resp_param;
    logic [7:0]  resp_size;
    logic [7:0]  resp_source;
    logic [63:0] resp_address;
    logic [63:0] resp_data;
    logic        resp_corrupt;
    logic [8:0]  resp_union;
    logic        resp_last;

    modport master (
        output req_valid, req_chanId, req_opcode, req_param, req_size, req_source,
               req_address, req_data, req_corrupt, req_union, resp_ready,
        input  req_ready, resp_valid, resp_chanId, resp_opcode, resp_param, resp_size,
               resp_source, resp_address, resp_data, resp_corrupt, resp_union, resp_last
    );

    modport slave (
        input  req_valid, req_chanId, req_opcode, req_param, req_size, req_source,
               req_address, req_data, req_corrupt, req_union, resp_ready,
        output req_ready, resp_valid, resp_chanId, resp_opcode, resp_param, resp_size,
               resp_source, resp_address, resp_data, resp_corrupt, resp_union, resp_last
    );
endinterface

// File: rtl/stl_tl_responder.sv
// rtl/stl_tl_responder.sv - TileLink manager on SerialTL frames with 64-bit backing memory; STL_RESP_ERR_EN enables denied/corrupt error responses.
module stl_tl_responder #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [63:0] ADDR_BASE   = 64'h0000_0000_8000_0000
) (
    input  logic                clk,
    input  logic                reset,
    stl_tl_responder_if.slave   bus,
    output logic [15:0]         debug_req_count,
    output logic [15:0]         debug_err_count,
    output logic [1:0]          debug_state
);
    localparam int          IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [63:0] SPAN  = 64'(DEPTH_WORDS) * 64'd8;
`ifdef STL_RESP_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    state_t      state;
    logic [2:0]  a_opcode;
    logic [7:0]  a_size;
    logic [7:0]  a_source;
    logic [63:0] a_address;
    logic [63:0] a_data;
    logic [7:0]  a_mask;
    logic        denied;

    logic [63:0] mem [DEPTH_WORDS];

    logic [63:0]      offset;
    logic [IDX_W-1:0] idx;
    logic [2:0]       align_mask;
    logic             in_range;
    logic             aligned;
    logic             is_get;
    logic             is_put;
    logic             legal;
    logic             mem_we;
    logic             unused_bits;

    always_comb begin
        offset   = a_address - ADDR_BASE;
        idx      = offset[IDX_W+2:3];
        in_range = (a_address >= ADDR_BASE) && (a_address < (ADDR_BASE + SPAN));
        case (a_size[1:0])
            2'd0:    align_mask = 3'b000;
            2'd1:    align_mask = 3'b001;
            2'd2:    align_mask = 3'b011;
            default: align_mask = 3'b111;
        endcase
        aligned = (a_address[2:0] & align_mask) == 3'b000;
        is_get  = (a_opcode == 3'd4);
        is_put  = (a_opcode == 3'd0) || (a_opcode == 3'd1);
        legal   = (is_get || is_put) && (a_size <= 8'd3) && in_range && aligned;
        // Gating on reset drops a write that coincides with the reset edge.
        mem_we  = (state == EXEC) && !reset && legal && is_put;
    end

    assign unused_bits = ^{bus.req_param, bus.req_corrupt, bus.req_union[8], offset};

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 8; i++) begin
                if (a_mask[i]) mem[idx][8*i +: 8] <= a_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            a_opcode          <= '0;
            a_size            <= '0;
            a_source          <= '0;
            a_address         <= '0;
            a_data            <= '0;
            a_mask            <= '0;
            denied            <= 1'b0;
            bus.resp_valid    <= 1'b0;
            bus.resp_chanId   <= '0;
            bus.resp_opcode   <= '0;
            bus.resp_param    <= '0;
            bus.resp_size     <= '0;
            bus.resp_source   <= '0;
            bus.resp_address  <= '0;
            bus.resp_data     <= '0;
            bus.resp_corrupt  <= 1'b0;
            debug_req_count   <= '0;
            debug_err_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Non-A frames are consumed here and silently dropped.
                    if (bus.req_valid && bus.req_chanId == 3'd0) begin
                        a_opcode  <= bus.req_opcode;
                        a_size    <= bus.req_size;
                        a_source  <= bus.req_source;
                        a_address <= bus.req_address;
                        a_data    <= bus.req_data;
                        a_mask    <= bus.req_union[7:0];
                        state     <= EXEC;
                        if (debug_req_count != 16'hFFFF) debug_req_count <= debug_req_count + 16'd1;
                    end
                end
                EXEC: begin
                    state            <= RESP;
                    bus.resp_valid   <= 1'b1;
                    bus.resp_chanId  <= 3'd3;
                    bus.resp_param   <= 3'd0;
                    bus.resp_address <= 64'd0;
                    bus.resp_size    <= a_size;
                    bus.resp_source  <= a_source;
                    bus.resp_opcode  <= is_get ? 3'd1 : 3'd0;
                    bus.resp_data    <= (legal && is_get) ? mem[idx] : 64'd0;
                    denied           <= !legal && ERR_EN;
                    bus.resp_corrupt <= !legal && ERR_EN && is_get;
                    if (!legal && debug_err_count != 16'hFFFF) debug_err_count <= debug_err_count + 16'd1;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state          <= IDLE;
                        bus.resp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_union = {8'd0, denied};
    assign bus.resp_last  = 1'b1;
    assign debug_state    = state;
endmodule

// File: tb/tb_stl_tl_responder.sv
// tb/tb_stl_tl_responder.sv - scoreboard bench for stl_tl_responder with directed TileLink frames.
module tb_stl_tl_responder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    stl_tl_responder_if bus();
    logic [15:0] debug_req_count;
    logic [15:0] debug_err_count;
    logic [1:0]  debug_state;

    stl_tl_responder dut (
        .clk             (clk),
        .reset           (reset),
        .bus             (bus.slave),
        .debug_req_count (debug_req_count),
        .debug_err_count (debug_err_count),
        .debug_state     (debug_state)
    );

`ifdef STL_RESP_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    typedef struct {
        logic [2:0]  opcode;
        logic [7:0]  size;
        logic [7:0]  source;
        logic [63:0] data;
        logic        denied;
        logic        corrupt;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int checks = 0;
    int failures = 0;
    int exp_req = 0;
    int exp_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && bus.resp_valid && bus.resp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp: got opcode %0d with empty scoreboard", bus.resp_opcode);
            end else begin
                m_e = sb.pop_front();
                chk("resp_opcode",  bus.resp_opcode,   m_e.opcode);
                chk("resp_size",    bus.resp_size,     m_e.size);
                chk("resp_source",  bus.resp_source,   m_e.source);
                chk("resp_data",    bus.resp_data,     m_e.data);
                chk("resp_denied",  bus.resp_union,    {8'd0, m_e.denied});
                chk("resp_corrupt", bus.resp_corrupt,  m_e.corrupt);
                chk("resp_chanId",  bus.resp_chanId,   3'd3);
                chk("resp_param",   bus.resp_param,    3'd0);
                chk("resp_address", bus.resp_address,  64'd0);
                chk("resp_last",    bus.resp_last,     1'b1);
            end
        end
    end

    task automatic chk_counters(input string tag);
        chk({tag, "_req_count"}, debug_req_count, 16'(exp_req));
        chk({tag, "_err_count"}, debug_err_count, 16'(exp_err));
    endtask

    // mode: 0 normal, 1 hold resp_ready low 4 cycles, 2 reset in EXEC, 3 reset in RESP.
    // For Gets, data is the expected read value and the inverse is driven on req_data.
    task automatic do_req(input logic [2:0] chan, input logic [2:0] opc, input logic [7:0] size,
                          input logic [7:0] src, input logic [63:0] addr, input logic [63:0] data,
                          input logic [7:0] mask, input bit legal, input int mode);
        int n;
        exp_t e;
        logic [63:0] snap_data;
        logic [2:0]  snap_opc;
        bus.req_valid   = 1'b1;
        bus.req_chanId  = chan;
        bus.req_opcode  = opc;
        bus.req_size    = size;
        bus.req_source  = src;
        bus.req_address = addr;
        bus.req_data    = (opc == 3'd4) ? ~data : data;
        bus.req_union   = {1'b0, mask};
        n = 0;
        while (!bus.req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL req_ready_timeout: got 0 expected 1");
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        if (chan != 3'd0) begin
            chk("drop_state", debug_state, 2'd0);
            chk("drop_resp_valid", bus.resp_valid, 1'b0);
            chk_counters("drop");
            repeat (2) @(posedge clk);
            #1 chk("drop_no_resp", bus.resp_valid, 1'b0);
            return;
        end
        exp_req++;
        chk("exec_state", debug_state, 2'd1);
        chk("lat_n1_valid", bus.resp_valid, 1'b0);
        chk("exec_req_ready", bus.req_ready, 1'b0);
        if (mode == 2) begin
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            exp_req = 0;
            exp_err = 0;
            chk("rst_exec_state", debug_state, 2'd0);
            chk("rst_exec_valid", bus.resp_valid, 1'b0);
            chk_counters("rst_exec");
            return;
        end
        e.opcode  = (opc == 3'd4) ? 3'd1 : 3'd0;
        e.size    = size;
        e.source  = src;
        e.data    = (legal && opc == 3'd4) ? data : 64'd0;
        e.denied  = !legal && ERR;
        e.corrupt = !legal && ERR && (opc == 3'd4);
        if (!legal) exp_err++;
        if (mode <= 1) sb.push_back(e);
        @(posedge clk); #1;
        chk("lat_n2_valid", bus.resp_valid, 1'b1);
        chk("resp_state", debug_state, 2'd2);
        if (mode == 3) begin
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            bus.resp_ready = 1'b1;
            exp_req = 0;
            exp_err = 0;
            chk("rst_resp_state", debug_state, 2'd0);
            chk("rst_resp_valid", bus.resp_valid, 1'b0);
            chk("rst_resp_data", bus.resp_data, 64'd0);
            chk_counters("rst_resp");
            return;
        end
        if (mode == 1) begin
            snap_data = bus.resp_data;
            snap_opc  = bus.resp_opcode;
            repeat (4) begin
                @(posedge clk); #1;
                chk("hold_valid", bus.resp_valid, 1'b1);
                chk("hold_data", bus.resp_data, snap_data);
                chk("hold_opcode", bus.resp_opcode, snap_opc);
                chk("hold_req_ready", bus.req_ready, 1'b0);
            end
            bus.resp_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk("idle_after_resp", debug_state, 2'd0);
        chk_counters("txn");
    endtask

    initial begin
        bus.req_valid   = 1'b0;
        bus.req_chanId  = '0;
        bus.req_opcode  = '0;
        bus.req_param   = '0;
        bus.req_size    = '0;
        bus.req_source  = '0;
        bus.req_address = '0;
        bus.req_data    = '0;
        bus.req_corrupt = 1'b0;
        bus.req_union   = '0;
        bus.resp_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        chk("rst_req_ready", bus.req_ready, 1'b1);
        chk("rst_resp_valid", bus.resp_valid, 1'b0);
        chk("rst_state", debug_state, 2'd0);
        chk("rst_resp_last", bus.resp_last, 1'b1);
        chk("rst_resp_data", bus.resp_data, 64'd0);
        chk("rst_resp_union", bus.resp_union, 9'd0);
        chk("rst_resp_chanId", bus.resp_chanId, 3'd0);
        chk_counters("rst");

        do_req(3'd0, 3'd0, 8'd3, 8'd5, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 1'b1, 0);
        bus.resp_ready = 1'b0;
        do_req(3'd0, 3'd4, 8'd3, 8'd7, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'h00, 1'b1, 1);
        do_req(3'd0, 3'd1, 8'd3, 8'd2, 64'h8000_0010, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F, 1'b1, 0);
        do_req(3'd0, 3'd4, 8'd3, 8'd3, 64'h8000_0010, 64'h1122_3344_BBBB_BBBB, 8'h00, 1'b1, 0);
        do_req(3'd0, 3'd1, 8'd2, 8'd4, 64'h8000_0014, 64'hCAFE_F00D_0000_0000, 8'hF0, 1'b1, 0);
        do_req(3'd0, 3'd4, 8'd3, 8'd6, 64'h8000_0010, 64'hCAFE_F00D_BBBB_BBBB, 8'h00, 1'b1, 0);
        do_req(3'd0, 3'd0, 8'd3, 8'd1, 64'h8000_07F8, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1, 0);
        do_req(3'd0, 3'd0, 8'd3, 8'd1, 64'h7FFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0, 0);
        do_req(3'd0, 3'd4, 8'd3, 8'd1, 64'h8000_07F8, 64'h0123_4567_89AB_CDEF, 8'h00, 1'b1, 0);
        do_req(3'd0, 3'd4, 8'd3, 8'd9, 64'h8000_0800, 64'd0, 8'h00, 1'b0, 0);
        do_req(3'd0, 3'd4, 8'd3, 8'd9, 64'h8000_0014, 64'd0, 8'h00, 1'b0, 0);
        do_req(3'd0, 3'd4, 8'd4, 8'd9, 64'h8000_0010, 64'd0, 8'h00, 1'b0, 0);
        do_req(3'd0, 3'd2, 8'd3, 8'd9, 64'h8000_0010, 64'd0, 8'hFF, 1'b0, 0);
        do_req(3'd0, 3'd4, 8'd0, 8'd10, 64'h8000_0013, 64'hCAFE_F00D_BBBB_BBBB, 8'h00, 1'b1, 0);
        do_req(3'd4, 3'd0, 8'd3, 8'd0, 64'h8000_0010, 64'hDEAD_DEAD_DEAD_DEAD, 8'hFF, 1'b1, 0);
        do_req(3'd0, 3'd0, 8'd3, 8'd0, 64'h8000_0010, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 1'b1, 2);
        do_req(3'd0, 3'd4, 8'd3, 8'd11, 64'h8000_0010, 64'hCAFE_F00D_BBBB_BBBB, 8'h00, 1'b1, 0);
        bus.resp_ready = 1'b0;
        do_req(3'd0, 3'd4, 8'd3, 8'd12, 64'h8000_0010, 64'hCAFE_F00D_BBBB_BBBB, 8'h00, 1'b1, 3);
        do_req(3'd0, 3'd4, 8'd3, 8'd13, 64'h8000_0010, 64'hCAFE_F00D_BBBB_BBBB, 8'h00, 1'b1, 0);

        repeat (3) @(posedge clk);
        #1 chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
